// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Instruction-memory read bus between the fetch unit (master) and the
// instruction memory (slave). One read may be outstanding at a time.
//
// Signals:
//   mem_rd     master->slave  one-cycle read request
//   mem_addr   master->slave  read address, valid while mem_rd=1
//   mem_rdata  slave->master  read data, valid while mem_done=1
//   mem_done   slave->master  read complete (1 or more cycles after mem_rd)
// -----------------------------------------------------------------------------
interface fetch_unit_if;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_done;

    modport master (
        output mem_rd,
        output mem_addr,
        input  mem_rdata,
        input  mem_done
    );

    modport slave (
        input  mem_rd,
        input  mem_addr,
        output mem_rdata,
        output mem_done
    );
endinterface : fetch_unit_if

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage. Issues one read at a time to instruction memory,
// holds the returned instruction until the fetch/decode register accepts it,
// and handles redirects (taken branches/jumps) and HALT, including a read
// that is still in flight when either arrives.
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst           asynchronous active-low reset
//   stall         downstream cannot accept an instruction this cycle
//   redirect      taken branch/jump, refetch from redirect_pc
//   redirect_pc   redirect target
//   halt          HALT decoded, stop fetching permanently
//   mem           instruction-memory read bus (master side)
//   outInstruct   instruction presented to the fetch/decode register
//   outPlusTwoPC  address of the presented instruction plus 2
//   fetch_stall   high when outInstruct is not a valid instruction
//   halted        high once the unit has stopped
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                redirect,
    input  logic [15:0]         redirect_pc,
    input  logic                halt,
    fetch_unit_if.master        mem,
    output logic [15:0]         outInstruct,
    output logic [15:0]         outPlusTwoPC,
    output logic                fetch_stall,
    output logic                halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_WAIT   = 3'd1,
        S_VALID  = 3'd2,
        S_DRAIN  = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic        halt_seen_q, halt_seen_d;
    logic [15:0] pc_plus2;
    logic        issue;

    // Natural 16-bit overflow gives the required 0xFFFE -> 0x0000 wrap.
    assign pc_plus2 = pc_q + 16'd2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            instr_q     <= NOP_INSTR;
            halt_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            halt_seen_q <= halt_seen_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        halt_seen_d = halt_seen_q;
        issue       = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (halt) begin
                    halt_seen_d = 1'b1;
                    state_d     = S_HALTED;
                end else if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = S_FETCH;
                end else begin
                    issue   = 1'b1;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (halt) begin
                    halt_seen_d = 1'b1;
                    state_d     = mem.mem_done ? S_HALTED : S_DRAIN;
                end else if (redirect) begin
                    // A completing read is for the old path: drop it.
                    pc_d    = redirect_pc;
                    state_d = mem.mem_done ? S_FETCH : S_DRAIN;
                end else if (mem.mem_done) begin
                    // Captured even under stall; VALID will hold it.
                    instr_d = mem.mem_rdata;
                    state_d = S_VALID;
                end
            end

            S_VALID: begin
                if (halt) begin
                    halt_seen_d = 1'b1;
                    state_d     = S_HALTED;
                end else if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = S_FETCH;
                end else if (!stall) begin
                    // Instruction consumed; the read of pc+2 goes out now,
                    // so pc advances to the address now in flight.
                    issue   = 1'b1;
                    pc_d    = pc_plus2;
                    state_d = S_WAIT;
                end
            end

            S_DRAIN: begin
                // Waiting out a stale read; only the completion matters.
                if (halt) begin
                    halt_seen_d = 1'b1;
                    state_d     = mem.mem_done ? S_HALTED : S_DRAIN;
                end else begin
                    if (redirect) begin
                        pc_d = redirect_pc;
                    end
                    if (mem.mem_done) begin
                        state_d = halt_seen_q ? S_HALTED : S_FETCH;
                    end
                end
            end

            S_HALTED: begin
                state_d = S_HALTED;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // The reset state is FETCH, so the request is masked while rst is low
    // and appears in the very cycle rst is released.
    assign mem.mem_rd   = issue & rst;
    assign mem.mem_addr = (state_q == S_VALID) ? pc_plus2 : pc_q;

    assign outInstruct  = (state_q == S_VALID) ? instr_q : NOP_INSTR;
    assign fetch_stall  = (state_q != S_VALID);
    assign outPlusTwoPC = pc_plus2;
    assign halted       = (state_q == S_HALTED);

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. A behavioural instruction memory with
// programmable latency answers reads; expected read addresses and expected
// presented instructions are queued by each scenario and popped by a
// scoreboard process. Scenario tasks also make their own inline checks.
// Inputs are driven 1 time unit after the rising edge, inline checks sample
// 3 units after it, memory and scoreboard act on the falling edge.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        halt = 1'b0;
    logic [15:0] outInstruct;
    logic [15:0] outPlusTwoPC;
    logic        fetch_stall;
    logic        halted;

    fetch_unit_if mem_bus ();

    fetch_unit #(
        .RESET_PC  (16'h0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .halt         (halt),
        .mem          (mem_bus.master),
        .outInstruct  (outInstruct),
        .outPlusTwoPC (outPlusTwoPC),
        .fetch_stall  (fetch_stall),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    int          n_vec  = 0;
    int          n_fail = 0;
    int          lat    = 1;
    logic [15:0] exp_addr[$];
    logic [31:0] exp_instr[$];   // {instruction, address+2}

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a == 16'h0006) ? 16'h1234 : (a ^ 16'hA5A5);
    endfunction

    // Instruction memory: request seen on the falling edge, mem_done held
    // for one full cycle 'lat' cycles later. Reset drops any pending read.
    logic        pending = 1'b0;
    int          cnt     = 0;
    logic [15:0] paddr   = 16'h0000;
    initial begin
        mem_bus.mem_done  = 1'b0;
        mem_bus.mem_rdata = 16'h0000;
    end
    always @(negedge clk) begin
        if (!rst) begin
            pending          = 1'b0;
            mem_bus.mem_done = 1'b0;
        end else begin
            mem_bus.mem_done = 1'b0;
            if (pending) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    mem_bus.mem_done  = 1'b1;
                    mem_bus.mem_rdata = mem_word(paddr);
                    pending           = 1'b0;
                end
            end
            if (mem_bus.mem_rd === 1'b1) begin
                pending = 1'b1;
                cnt     = lat;
                paddr   = mem_bus.mem_addr;
            end
        end
    end

    task automatic sb_monitor();
        logic [15:0] a;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (mem_bus.mem_rd === 1'b1) begin
                    n_vec++;
                    if (exp_addr.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_addr: unexpected read at %h, none required", mem_bus.mem_addr);
                    end else begin
                        a = exp_addr.pop_front();
                        if (mem_bus.mem_addr !== a) begin
                            n_fail++;
                            $display("FAIL sb_addr: mem_addr=%h required %h", mem_bus.mem_addr, a);
                        end
                    end
                end
                if (fetch_stall === 1'b0 && !stall && !redirect && !halt) begin
                    n_vec++;
                    if (exp_instr.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_instr: unexpected instruction %h consumed", outInstruct);
                    end else begin
                        e = exp_instr.pop_front();
                        if (outInstruct !== e[31:16] || outPlusTwoPC !== e[15:0]) begin
                            n_fail++;
                            $display("FAIL sb_instr: instr=%h pc2=%h required instr=%h pc2=%h",
                                     outInstruct, outPlusTwoPC, e[31:16], e[15:0]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; halt = 1'b0; redirect_pc = 16'h0000;
        exp_addr.delete();
        exp_instr.delete();
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_vec++; if (mem_bus.mem_rd !== 1'b0) begin n_fail++; $display("FAIL rst_mem_rd: got %b required 0", mem_bus.mem_rd); end
        n_vec++; if (fetch_stall !== 1'b1) begin n_fail++; $display("FAIL rst_fetch_stall: got %b required 1", fetch_stall); end
        n_vec++; if (outInstruct !== NOP) begin n_fail++; $display("FAIL rst_instr: got %h required %h", outInstruct, NOP); end
        n_vec++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted: got %b required 0", halted); end
        n_vec++; if (outPlusTwoPC !== 16'h0002) begin n_fail++; $display("FAIL rst_pc2: got %h required 0002", outPlusTwoPC); end
    endtask

    task automatic test_sequential();
        logic [8:1] fs_tbl;
        fs_tbl = 8'b10101011;   // fetch_stall in cycles 8..1 after release
        apply_reset();
        lat = 1;
        exp_addr.push_back(16'h0000);
        exp_addr.push_back(16'h0002);
        exp_addr.push_back(16'h0004);
        exp_addr.push_back(16'h0006);
        exp_instr.push_back({mem_word(16'h0000), 16'h0002});
        exp_instr.push_back({mem_word(16'h0002), 16'h0004});
        exp_instr.push_back({mem_word(16'h0004), 16'h0006});
        @(posedge clk); #1; rst = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            #2;
            n_vec++;
            if (fetch_stall !== fs_tbl[c]) begin
                n_fail++;
                $display("FAIL seq_timing cycle %0d: fetch_stall=%b required %b", c, fetch_stall, fs_tbl[c]);
            end
            @(posedge clk); #1;
        end
        stall = 1'b1;   // hold the instruction at 0x0006 in VALID
    endtask

    task automatic test_stall();
        for (int c = 0; c < 3; c++) begin
            #2;
            n_vec++; if (outInstruct !== 16'h1234) begin n_fail++; $display("FAIL stall_instr: got %h required 1234", outInstruct); end
            n_vec++; if (mem_bus.mem_rd !== 1'b0) begin n_fail++; $display("FAIL stall_mem_rd: got %b required 0", mem_bus.mem_rd); end
            n_vec++; if (outPlusTwoPC !== 16'h0008) begin n_fail++; $display("FAIL stall_pc2: got %h required 0008", outPlusTwoPC); end
            @(posedge clk); #1;
        end
        exp_instr.push_back({16'h1234, 16'h0008});
        exp_addr.push_back(16'h0008);
        stall = 1'b0;
        #2;
        n_vec++;
        if (mem_bus.mem_rd !== 1'b1 || mem_bus.mem_addr !== 16'h0008) begin
            n_fail++;
            $display("FAIL stall_release: rd=%b addr=%h required rd=1 addr=0008", mem_bus.mem_rd, mem_bus.mem_addr);
        end
        @(posedge clk); #1; stall = 1'b1;
    endtask

    task automatic test_redirect_drain();
        int cyc;
        bit seen;
        apply_reset();
        lat = 4;
        exp_addr.push_back(16'h0000);
        @(posedge clk); #1; rst = 1'b1;                            // cycle 1: FETCH
        @(posedge clk); #1;                                        // cycle 2: WAIT
        @(posedge clk); #1; redirect = 1'b1; redirect_pc = 16'h0040; // cycle 3
        #2;
        n_vec++; if (fetch_stall !== 1'b1) begin n_fail++; $display("FAIL drain_redir_stall: got %b required 1", fetch_stall); end
        @(posedge clk); #1;
        redirect = 1'b0;
        stall    = 1'b1;
        exp_addr.push_back(16'h0040);
        cyc  = 4;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            #2;
            if (mem_bus.mem_rd === 1'b1) begin
                seen = 1'b1;
            end else begin
                n_vec++;
                if (fetch_stall !== 1'b1 || outInstruct !== NOP) begin
                    n_fail++;
                    $display("FAIL drain_hold cycle %0d: fetch_stall=%b instr=%h required 1/%h", cyc, fetch_stall, outInstruct, NOP);
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        n_vec++;
        if (!seen || cyc != 6) begin
            n_fail++;
            $display("FAIL drain_exit: refetch seen=%0d in cycle %0d required cycle 6", seen, cyc);
        end
        n_vec++; if (mem_bus.mem_addr !== 16'h0040) begin n_fail++; $display("FAIL drain_target: got %h required 0040", mem_bus.mem_addr); end
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(posedge clk); #3;
            if (fetch_stall === 1'b0) seen = 1'b1;
        end
        n_vec++; if (!seen) begin n_fail++; $display("FAIL drain_valid_timeout: fetch_stall=%b required 0", fetch_stall); end
        n_vec++; if (outInstruct !== mem_word(16'h0040)) begin n_fail++; $display("FAIL drain_instr: got %h required %h", outInstruct, mem_word(16'h0040)); end
        n_vec++; if (outPlusTwoPC !== 16'h0042) begin n_fail++; $display("FAIL drain_pc2: got %h required 0042", outPlusTwoPC); end
    endtask

    task automatic test_redirect_halt();
        @(posedge clk); #1;
        stall = 1'b0; redirect = 1'b1; halt = 1'b1; redirect_pc = 16'h1000;
        #2;
        n_vec++; if (mem_bus.mem_rd !== 1'b0) begin n_fail++; $display("FAIL halt_gate: mem_rd=%b required 0", mem_bus.mem_rd); end
        @(posedge clk); #1;
        redirect = 1'b0; halt = 1'b0;
        #2;
        n_vec++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag: got %b required 1", halted); end
        n_vec++; if (fetch_stall !== 1'b1 || outInstruct !== NOP) begin n_fail++; $display("FAIL halt_out: stall=%b instr=%h required 1/%h", fetch_stall, outInstruct, NOP); end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #3;
            n_vec++;
            if (mem_bus.mem_rd !== 1'b0 || halted !== 1'b1 || outPlusTwoPC !== 16'h0042) begin
                n_fail++;
                $display("FAIL halt_frozen: rd=%b halted=%b pc2=%h required 0/1/0042", mem_bus.mem_rd, halted, outPlusTwoPC);
            end
        end
    endtask

    task automatic test_wrap();
        bit seen;
        apply_reset();
        lat = 1;
        exp_addr.push_back(16'hFFFE);
        exp_addr.push_back(16'h0000);
        exp_instr.push_back({mem_word(16'hFFFE), 16'h0000});
        @(posedge clk); #1;
        rst = 1'b1; redirect = 1'b1; redirect_pc = 16'hFFFE;
        #2;
        n_vec++; if (mem_bus.mem_rd !== 1'b0) begin n_fail++; $display("FAIL wrap_gate: mem_rd=%b required 0", mem_bus.mem_rd); end
        @(posedge clk); #1; redirect = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(posedge clk); #3;
            if (fetch_stall === 1'b0) seen = 1'b1;
        end
        n_vec++; if (!seen) begin n_fail++; $display("FAIL wrap_timeout: fetch_stall=%b required 0", fetch_stall); end
        n_vec++; if (mem_bus.mem_addr !== 16'h0000) begin n_fail++; $display("FAIL wrap_addr: got %h required 0000", mem_bus.mem_addr); end
        n_vec++; if (outPlusTwoPC !== 16'h0000) begin n_fail++; $display("FAIL wrap_pc2: got %h required 0000", outPlusTwoPC); end
        @(posedge clk); #1; stall = 1'b1;   // WAIT for 0x0000; hold it once VALID
    endtask

    task automatic test_reset_mid_wait();
        @(posedge clk); #1;                 // VALID with the word from 0x0000
        lat = 4;
        exp_instr.push_back({mem_word(16'h0000), 16'h0002});
        exp_addr.push_back(16'h0002);
        stall = 1'b0;
        @(posedge clk); #1; stall = 1'b1;  // WAIT on 0x0002
        #2; rst = 1'b0;
        #1;
        n_vec++; if (mem_bus.mem_rd !== 1'b0) begin n_fail++; $display("FAIL midrst_rd: got %b required 0", mem_bus.mem_rd); end
        n_vec++; if (fetch_stall !== 1'b1) begin n_fail++; $display("FAIL midrst_stall: got %b required 1", fetch_stall); end
        n_vec++; if (outInstruct !== NOP) begin n_fail++; $display("FAIL midrst_instr: got %h required %h", outInstruct, NOP); end
        n_vec++; if (halted !== 1'b0) begin n_fail++; $display("FAIL midrst_halted: got %b required 0", halted); end
        n_vec++; if (outPlusTwoPC !== 16'h0002) begin n_fail++; $display("FAIL midrst_pc2: got %h required 0002", outPlusTwoPC); end
        repeat (2) @(posedge clk);
        exp_addr.push_back(16'h0000);
        @(posedge clk); #1; rst = 1'b1; stall = 1'b0;
        #2;
        n_vec++;
        if (mem_bus.mem_rd !== 1'b1 || mem_bus.mem_addr !== 16'h0000) begin
            n_fail++;
            $display("FAIL midrst_refetch: rd=%b addr=%h required 1/0000", mem_bus.mem_rd, mem_bus.mem_addr);
        end
        @(posedge clk); #1; rst = 1'b0;
    endtask

    initial begin
        fork
            sb_monitor();
        join_none
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_drain();
        test_redirect_halt();
        test_wrap();
        test_reset_mid_wait();
        n_vec++;
        if (exp_addr.size() != 0 || exp_instr.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: %0d reads and %0d instructions never seen, required 0",
                     exp_addr.size(), exp_instr.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000: PC loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 16'h0800: bubble instruction driven when no valid instruction is held.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port stall  input  1  downstream (fetch/decode register) cannot accept an instruction this cycle.
REQ-006 SHALL have port redirect  input  1  taken branch/jump; refetch from redirect_pc.
REQ-007 SHALL have port redirect_pc  input  16  redirect target address.
REQ-008 SHALL have port halt  input  1  HALT decoded; stop fetching permanently.
REQ-009 SHALL have port mem_rd  output  1  one-cycle instruction-memory read request.
REQ-010 SHALL have port mem_addr  output  16  read address, valid when mem_rd=1.
REQ-011 SHALL have port mem_rdata  input  16  read data, valid when mem_done=1.
REQ-012 SHALL have port mem_done  input  1  read complete; latency 1 or more cycles after mem_rd; one outstanding read maximum.
REQ-013 SHALL have port outInstruct  output  16  instruction to the fetch/decode register.
REQ-014 SHALL have port outPlusTwoPC  output  16  address of the presented instruction plus 2.
REQ-015 SHALL have port fetch_stall  output  1  high when outInstruct is not a valid instruction.
REQ-016 SHALL have port halted  output  1  high in HALTED.

Function
REQ-017 SHALL implement states FETCH, WAIT, VALID, DRAIN, HALTED; pc register (16) holds the address of the instruction being fetched or held; instr_reg (16); halt_seen flag.
REQ-018 SHALL drive mem_rd = (FETCH, or VALID with stall=0), gated off when redirect=1 or halt=1.
REQ-019 SHALL drive mem_addr = pc+2 in VALID, pc otherwise; pc+2 wraps modulo 2^16 (16'hFFFE -> 16'h0000).
REQ-020 FETCH: with mem_rd issued, go to WAIT.
REQ-021 WAIT: on mem_done, load instr_reg <= mem_rdata and go to VALID regardless of stall; otherwise remain.
REQ-022 VALID: outInstruct = instr_reg, fetch_stall=0; with stall=1, hold all state; with stall=0, the instruction is consumed: pc <= pc+2 and go to WAIT (the next request is issued in the same cycle).
REQ-023 In every state except VALID: outInstruct = NOP_INSTR and fetch_stall=1.
REQ-024 outPlusTwoPC SHALL be pc+2 at all times, with the same wrap rule.
REQ-025 redirect (halt=0): pc <= redirect_pc. Next state: FETCH, VALID -> FETCH. WAIT with mem_done=0 -> DRAIN. WAIT with mem_done=1 -> FETCH, data discarded. DRAIN -> DRAIN, target still updated.
REQ-026 DRAIN: mem_done discards the data; then go to HALTED if halt_seen, else FETCH.
REQ-027 halt takes precedence over redirect and sets halt_seen. Next state: FETCH, VALID -> HALTED. WAIT/DRAIN with mem_done=0 -> DRAIN. WAIT/DRAIN with mem_done=1 -> HALTED.
REQ-028 HALTED: mem_rd=0, halted=1, pc frozen; exit only by reset.
REQ-029 mem_done outside WAIT/DRAIN SHALL be ignored.

Reset
REQ-030 rst=0 SHALL asynchronously set state=FETCH, pc=RESET_PC, instr_reg=NOP_INSTR, halt_seen=0, including mid-read. A mem_done for a read issued before reset SHALL NOT be required to be handled.
REQ-031 During reset: mem_rd=0, fetch_stall=1, outInstruct=NOP_INSTR, halted=0. First request SHALL issue at RESET_PC in the first cycle after rst rises.

Verification
REQ-032 Reset release, memory latency 1, stall=0: mem_rd at 0x0000 in cycle 1, then 0x0002, 0x0004; each instruction presented one cycle after its mem_done, with outPlusTwoPC = address+2.
REQ-033 stall=1 for 3 cycles while VALID with instr_reg=0x1234: outInstruct holds 0x1234, mem_rd=0, pc unchanged; release -> request at pc+2.
REQ-034 redirect to 0x0040 while WAIT with memory latency 4: DRAIN until mem_done, data discarded, fetch_stall=1 throughout; next mem_addr = 0x0040.
REQ-035 redirect and halt asserted together in VALID: HALTED next cycle, halted=1, no further mem_rd, pc not changed to redirect_pc.
REQ-036 pc=0xFFFE consumed -> mem_addr=0x0000, outPlusTwoPC=0x0000 while presenting the instruction at 0xFFFE.
REQ-037 rst asserted during WAIT: outputs immediately return to reset values; after release, refetch starts at RESET_PC.
